bin_to_bcd_serial: RTL and testbench

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It sits directly upstream of the BCD-to-Excess-3 stage: each 4-bit digit of `bcd` feeds one BCD-to-XS-3 converter, so a binary count or value can be shown or processed in XS-3 form. A start/busy/done handshake controls it, and the result is held stable until the next conversion completes.

---
 rtl/bcd_pkg.sv | 26 ++
 rtl/bcd_add3_cell.sv | 17 +
 rtl/bin_to_bcd_serial.sv | 92 +++++++++
 tb/tb_bin_to_bcd_serial.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions: FSM state encoding, digit width, add-3 threshold
// and the elaboration-time digit-capacity check.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // True when DIGITS decimal digits can hold every BIN_W-bit unsigned value.
  function automatic logic digits_fit(input int unsigned bin_w, input int unsigned digits);
    logic [127:0] p;
    logic [127:0] maxv;
    p = 128'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 128'd10;
    end
    maxv = (128'd1 << bin_w) - 128'd1;
    return (p > maxv);
  endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_add3_cell
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  // Conditional +3, 4-bit wrap (never overflows for inputs 0..9).
  always_comb begin
    dout = din;
    if (din >= ADD3_THRESH) begin
      dout = din + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Serial binary-to-BCD converter (shift-and-add-3), one bit per clock,
// with start/busy/done handshake and a held result register.
module bin_to_bcd_serial
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

  localparam int unsigned BCD_W  = BCD_DIGIT_W * DIGITS;
  localparam int unsigned WORK_W = BCD_W + BIN_W;
  localparam int unsigned CNT_W  = $clog2(BIN_W + 1);

  if (!digits_fit(BIN_W, DIGITS)) begin : g_capacity_check
    $error("bin_to_bcd_serial: DIGITS too small for BIN_W");
  end

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [WORK_W-1:0] work;
  logic [WORK_W-1:0] work_adj;
  logic [WORK_W-1:0] work_next;

  assign work_adj[BIN_W-1:0] = work[BIN_W-1:0];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_add3_cell u_add3 (
      .din  (work[BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .dout (work_adj[BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W])
    );
  end

  // Corrected register shifted left by one: the per-cycle dabble step.
  always_comb begin
    work_next = work_adj << 1;
  end

  // Conversion FSM with registered handshake and result.
  // bcd/done are loaded on the edge entering DONE so they are visible
  // during the DONE cycle itself without any combinational output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
      work  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            work  <= {{BCD_W{1'b0}}, bin};
            cnt   <= CNT_W'(BIN_W);
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          work <= work_next;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            bcd   <= work_next[WORK_W-1 -: BCD_W];
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Directed self-checking bench for bin_to_bcd_serial with a result scoreboard.
module tb_bin_to_bcd_serial;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_pushed = 0;
  logic [11:0] exp_q[$];

  bin_to_bcd_serial #(.BIN_W(8), .DIGITS(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [11:0] to_bcd(input int unsigned v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int unsigned v);
    exp_q.push_back(to_bcd(v));
    n_pushed++;
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(bcd), 32'hFFFF_FFFF);
      end else begin
        chk("sb_bcd", 32'(bcd), 32'(exp_q.pop_front()));
      end
      chk("digits_le9", 32'((bcd[11:8] <= 4'd9) && (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9)), 32'd1);
    end
  end

  // Starts a conversion from IDLE (called just after a rising edge) and
  // checks the full busy/done/bcd timeline through the return to IDLE.
  task automatic run_one(input int unsigned v);
    start = 1'b1;
    bin   = 8'(v);
    push_exp(v);
    @(posedge clk); #1;
    start = 1'b0;
    bin   = ~8'(v);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("busy_t", 32'(busy), 32'(k <= 9));
      chk("done_t", 32'(done), 32'(k == 9));
      if (k >= 9) chk("bcd_t", 32'(bcd), 32'(to_bcd(v)));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [11:0] held;
    logic [3:0]  d0;

    // Reset asserted together with start: nothing may begin.
    rst = 1'b1; start = 1'b1; bin = 8'd55;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd",  32'(bcd),  32'd0);
    rst = 1'b0; start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    @(posedge clk); #1;

    // Full scale, then zero and edge values.
    run_one(255);
    run_one(0);
    run_one(9);
    run_one(10);
    run_one(99);
    d0 = bcd[3:0] + 4'd3;
    chk("xs3_digit0_99", 32'(d0), 32'hC);
    run_one(100);

    // Start while busy (SHIFT at cycle 3, DONE at cycle 9) is ignored.
    start = 1'b1; bin = 8'd200;
    push_exp(200);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      start = (k == 3 || k == 9);
      bin   = start ? 8'd17 : 8'd200;
      @(negedge clk);
      chk("rej_done", 32'(done), 32'(k == 9));
      chk("rej_busy", 32'(busy), 32'(k <= 9));
      if (k >= 9) chk("rej_bcd", 32'(bcd), 32'h200);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("rej_bcd_hold", 32'(bcd), 32'h200);
    @(posedge clk); #1;

    // Reset during SHIFT discards the conversion.
    start = 1'b1; bin = 8'd173;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_bcd",  32'(bcd),  32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("mid_rst_nodone", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    run_one(42);

    // Reset and start on the same edge after activity.
    rst = 1'b1; start = 1'b1; bin = 8'd77;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("prio_busy", 32'(busy), 32'd0);
    end
    @(posedge clk); #1;

    // Back-to-back with start held high, bin stepping 0..255.
    start = 1'b1; bin = 8'd0;
    push_exp(0);
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      if (i < 255) begin
        bin = 8'(i + 1);
        push_exp(i + 1);
      end else begin
        start = 1'b0;
      end
      held = bcd;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        chk("b2b_done", 32'(done), 32'(k == 9));
        if (k < 9)  chk("b2b_stable", 32'(bcd), 32'(held));
        if (k >= 9) chk("b2b_bcd", 32'(bcd), 32'(to_bcd(i)));
      end
    end
    repeat (5) @(negedge clk);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("done_count", 32'(n_done), 32'(n_pushed));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
